// File: rtl/ascon_arb_pkg.sv
// Shared types and defaults for the ASCON engine round-robin arbiter.
// The state enum always carries ST_ABORT; it is only reachable when the
// ASCON_ARB_TIMEOUT_EN macro is defined.
package ascon_arb_pkg;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } arb_state_t;

  localparam arb_state_t RST_STATE     = ST_IDLE;
  localparam logic       RST_ENG_RST_N = 1'b1;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ascon_rr_picker.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module ascon_rr_picker
  import ascon_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] winner_o
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

  // Modular add of two indices, both already below N_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_W) s = s - N_W;
    return s[IDX_W-1:0];
  endfunction

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] rot_idx;

  // Rotate, priority-encode the lowest set bit, un-rotate.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    rot     = '0;
    rot_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req_i[wrap_add(IDX_W'(i), ptr_i)];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = IDX_W'(i);
    end
    valid_o  = |req_i;
    winner_o = wrap_add(rot_idx, ptr_i);
  end

endmodule

// File: rtl/ascon_rr_arbiter.sv
// Round-robin sequencer sharing one ASCON engine among N_REQ requesters.
// Holds grant and operand-select for the whole job, pulses engine start,
// waits for engine end and returns a per-requester done pulse.
// Optional watchdog: define ASCON_ARB_TIMEOUT_EN to abort jobs whose engine
// never signals end within TIMEOUT_CYCLES busy cycles.
module ascon_rr_arbiter
  import ascon_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(N_REQ)
`ifdef ASCON_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] done_o,
  output logic [N_REQ-1:0] err_o,
  output logic [IDX_W-1:0] sel_o,
  output logic             busy_o,
  output logic             eng_start_o,
  input  logic             eng_end_i,
  output logic             eng_rst_n_o
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [N_REQ-1:0] sel_oh;

`ifdef ASCON_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  ascon_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  assign ptr_next = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;

  // Next-state, pointer, owner-index and watchdog counter logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
`ifdef ASCON_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_START;
      ST_START: begin
        state_d = ST_BUSY;
`ifdef ASCON_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_BUSY: begin
        if (eng_end_i) begin
          state_d = ST_DONE;
`ifdef ASCON_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_DONE, ST_ABORT: begin
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and index registers; async reset drops any job in flight.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      sel_q   <= '0;
`ifdef ASCON_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
`ifdef ASCON_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs decoded purely from registered state and owner index.
  always_comb begin
    sel_oh          = '0;
    sel_oh[sel_q]   = 1'b1;
    gnt_o           = '0;
    done_o          = '0;
    err_o           = '0;
    eng_rst_n_o     = RST_ENG_RST_N;
    sel_o           = sel_q;
    busy_o          = (state_q != ST_IDLE);
    eng_start_o     = (state_q == ST_START);
    if (state_q == ST_GRANT || state_q == ST_START || state_q == ST_BUSY) gnt_o = sel_oh;
    if (state_q == ST_DONE) done_o = sel_oh;
`ifdef ASCON_ARB_TIMEOUT_EN
    if (state_q == ST_ABORT) begin
      err_o       = sel_oh;
      eng_rst_n_o = 1'b0;
    end
`endif
  end

endmodule
